uart_apb_bridge: RTL
====================

UART_APB_BRIDGE -- requirements
Module: uart_apb_bridge

Interface
REQ-001 Parameter CLKS_PER_BIT, default 87, SHALL set PCLK cycles per UART bit time (legal range 4..65535).
REQ-002 PCLK  input  1  sole clock; all logic SHALL be clocked on its rising edge.
REQ-003 PRESETn  input  1  reset; SHALL be synchronous and active-low.
REQ-004 RXD  input  1  asynchronous UART receive line; idle high, 8N1, LSB first.
REQ-005 TXD  output  1  UART transmit line; idle high, 8N1, LSB first.
REQ-006 PSEL  output  1  APB select to the debugger APB slave.
REQ-007 PENABLE  output  1  APB enable.
REQ-008 PWRITE  output  1  APB direction; 1 = write.
REQ-009 PADDR  output  5  APB register address.
REQ-010 PWDATA  output  8  APB write data.
REQ-011 PRDATA  input  8  APB read data.
REQ-012 PREADY  input  1  APB ready.

Function
REQ-013 RXD SHALL pass through a 2-flop synchronizer before any use.
REQ-014 The receiver SHALL detect a start bit on a synchronized high-to-low transition, re-check low at CLKS_PER_BIT/2, then sample each data bit and the stop bit at one-bit intervals from that point.
REQ-015 A stop bit sampled low SHALL be a framing error: the byte is discarded, no state change.
REQ-016 Command byte: bit7 = write, bits6:5 reserved, bits4:0 = PADDR.
REQ-017 Control FSM states SHALL be IDLE, GET_DATA, SETUP, ACCESS, RESPOND.
REQ-018 IDLE: a valid command with bits6:5 != 0 SHALL queue response 0x15 (NAK) and go to RESPOND with no APB transfer.
REQ-019 IDLE: a valid read command SHALL go to SETUP; a valid write command SHALL go to GET_DATA.
REQ-020 GET_DATA: the next received byte SHALL load PWDATA and go to SETUP.
REQ-021 SETUP SHALL last exactly one cycle with PSEL=1, PENABLE=0; PADDR, PWRITE, PWDATA stable from SETUP through the end of ACCESS.
REQ-022 ACCESS SHALL hold PSEL=1, PENABLE=1 until a cycle with PREADY=1; PRDATA SHALL be captured in that cycle; PSEL and PENABLE SHALL be 0 in the following cycle.
REQ-023 On completion the response byte SHALL be the captured PRDATA for reads and 0x06 (ACK) for writes.
REQ-024 RESPOND: TXD start bit SHALL begin the cycle after entry; the state SHALL return to IDLE the cycle after the stop bit's final cycle.
REQ-025 Bytes completing reception in SETUP, ACCESS or RESPOND SHALL be silently dropped; the receiver itself keeps running.
REQ-026 Exactly one APB transfer per accepted command; PSEL SHALL never assert outside SETUP/ACCESS.

Reset
REQ-027 While PRESETn=0 at a clock edge: TXD=1, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, FSM=IDLE, receiver idle, bit/baud counters 0.
REQ-028 Reset mid-transfer or mid-character SHALL abandon it; no partial byte or response SHALL be emitted after release.

Configuration
REQ-029 Macro UART_APB_TIMEOUT_EN defined: an 8-bit counter SHALL abort ACCESS after 255 cycles without PREADY, deassert PSEL/PENABLE next cycle, and respond 0xEE.
REQ-030 Macro UART_APB_TIMEOUT_EN undefined: ACCESS SHALL wait for PREADY indefinitely; no counter logic present.

Structure
REQ-031 Response codes (ACK 0x06, NAK 0x15, TIMEOUT 0xEE), FSM state encodings and command field positions SHALL live in the shared package debug_defs.
REQ-032 The receiver (synchronizer, start detect, sampling, framing check) SHALL be the sub-module uart_byte_rx; transmitter and FSM stay in uart_apb_bridge.

Verification (CLKS_PER_BIT=4 on bench)
REQ-033 Send 0x81 then 0x5A, PREADY=1 -> one APB write PADDR=1, PWDATA=0x5A, SETUP then 1 ACCESS cycle; TXD returns 0x06.
REQ-034 Send 0x00, slave PREADY low 3 ACCESS cycles, PRDATA=0xC3 -> ACCESS lasts 4 cycles; TXD returns 0xC3.
REQ-035 Send 0x40 -> no PSEL activity; TXD returns 0x15.
REQ-036 Send 0x02 with stop bit low, then valid 0x02 -> first ignored; exactly one read at PADDR=2.
REQ-037 Send 0x81, assert PRESETn=0 for 1 cycle before data byte -> all outputs reset values; next 0x00 command handled normally.
REQ-038 With UART_APB_TIMEOUT_EN, read with PREADY tied 0 -> PSEL drops after 255 ACCESS cycles; TXD returns 0xEE.

Source files
------------

// File: rtl/debug_defs.sv
// debug_defs: definitions shared by the UART-to-APB debug bridge.
//   Response codes, command byte field positions, access timeout load value,
//   control FSM and receiver state encodings.
//   UART_APB_TIMEOUT_EN (define) enables the ACCESS timeout in uart_apb_bridge.
package debug_defs;

  localparam logic [7:0] RESP_ACK     = 8'h06;
  localparam logic [7:0] RESP_NAK     = 8'h15;
  localparam logic [7:0] RESP_TIMEOUT = 8'hEE;

  // Command byte layout: [7] write, [6:5] reserved (must be 0), [4:0] PADDR
  localparam int CMD_WRITE_BIT = 7;
  localparam int CMD_RSV_MSB   = 6;
  localparam int CMD_RSV_LSB   = 5;
  localparam int CMD_ADDR_MSB  = 4;
  localparam int CMD_ADDR_LSB  = 0;

  // Loaded on entry to ACCESS; terminal count reached on the 255th ACCESS cycle
  localparam logic [7:0] TIMEOUT_LOAD = 8'd254;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GET_DATA = 3'd1,
    ST_SETUP    = 3'd2,
    ST_ACCESS   = 3'd3,
    ST_RESPOND  = 3'd4
  } ctrl_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  function automatic logic cmd_reserved_set(input logic [7:0] cmd);
    return |cmd[CMD_RSV_MSB:CMD_RSV_LSB];
  endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 UART byte receiver.
//   PCLK       in   clock
//   PRESETn    in   synchronous active-low reset
//   RXD        in   asynchronous serial line (idle high)
//   byte_valid out  one-cycle pulse when a byte with a good stop bit arrives
//   byte_data  out  received byte, valid with byte_valid
// Bytes whose stop bit samples low are dropped without any pulse.
module uart_byte_rx
  import debug_defs::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       RXD,
  output logic       byte_valid,
  output logic [7:0] byte_data
);

  localparam logic [15:0] BIT_LOAD  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LOAD = 16'(CLKS_PER_BIT / 2 - 1);

  logic        rxd_meta;
  logic        rxd_sync;
  logic        rxd_prev;
  rx_state_t   rx_state;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift_reg;

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      rxd_meta   <= 1'b1;
      rxd_sync   <= 1'b1;
      rxd_prev   <= 1'b1;
      rx_state   <= RX_IDLE;
      baud_cnt   <= 16'd0;
      bit_idx    <= 3'd0;
      shift_reg  <= 8'd0;
      byte_valid <= 1'b0;
      byte_data  <= 8'd0;
    end else begin
      rxd_meta   <= RXD;
      rxd_sync   <= rxd_meta;
      rxd_prev   <= rxd_sync;
      byte_valid <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rxd_prev && !rxd_sync) begin
            baud_cnt <= HALF_LOAD;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (baud_cnt != 16'd0) begin
            baud_cnt <= baud_cnt - 16'd1;
          end else if (!rxd_sync) begin
            baud_cnt <= BIT_LOAD;
            bit_idx  <= 3'd0;
            rx_state <= RX_DATA;
          end else begin
            // glitch, not a real start bit
            rx_state <= RX_IDLE;
          end
        end
        RX_DATA: begin
          if (baud_cnt != 16'd0) begin
            baud_cnt <= baud_cnt - 16'd1;
          end else begin
            shift_reg <= {rxd_sync, shift_reg[7:1]};
            baud_cnt  <= BIT_LOAD;
            bit_idx   <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) rx_state <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (baud_cnt != 16'd0) begin
            baud_cnt <= baud_cnt - 16'd1;
          end else begin
            if (rxd_sync) begin
              byte_valid <= 1'b1;
              byte_data  <= shift_reg;
            end
            rx_state <= RX_IDLE;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_apb_bridge.sv
// uart_apb_bridge: UART command interface driving one APB master transfer per
// command, answering with a single response byte on TXD.
//   PCLK, PRESETn        clock, synchronous active-low reset
//   RXD / TXD            8N1 serial in / out, idle high
//   PSEL, PENABLE, PWRITE, PADDR[4:0], PWDATA[7:0]   APB master outputs
//   PRDATA[7:0], PREADY                              APB slave returns
// Optional: define UART_APB_TIMEOUT_EN to abort ACCESS after 255 cycles
// without PREADY and respond 0xEE.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for a command byte
// GET_DATA | write command accepted, waiting for the data byte
// SETUP    | APB setup phase (PSEL=1, PENABLE=0), one cycle
// ACCESS   | APB access phase, waiting for PREADY
// RESPOND  | shifting the response byte out on TXD
module uart_apb_bridge
  import debug_defs::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       RXD,
  output logic       TXD,
  output logic       PSEL,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [4:0] PADDR,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA,
  input  logic       PREADY
);

  localparam logic [15:0] BIT_LOAD = 16'(CLKS_PER_BIT - 1);

  logic        rx_valid;
  logic [7:0]  rx_data;
  ctrl_state_t state;
  logic [7:0]  resp_byte;
  logic        tx_active;
  logic [8:0]  tx_shift;
  logic [3:0]  tx_bits_left;
  logic [15:0] tx_baud_cnt;
`ifdef UART_APB_TIMEOUT_EN
  logic [7:0]  to_cnt;
`endif

  uart_byte_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .PCLK       (PCLK),
    .PRESETn    (PRESETn),
    .RXD        (RXD),
    .byte_valid (rx_valid),
    .byte_data  (rx_data)
  );

  // Received bytes are only consumed in IDLE and GET_DATA; elsewhere they fall away.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state        <= ST_IDLE;
      TXD          <= 1'b1;
      PSEL         <= 1'b0;
      PENABLE      <= 1'b0;
      PWRITE       <= 1'b0;
      PADDR        <= 5'd0;
      PWDATA       <= 8'd0;
      resp_byte    <= 8'd0;
      tx_active    <= 1'b0;
      tx_shift     <= 9'd0;
      tx_bits_left <= 4'd0;
      tx_baud_cnt  <= 16'd0;
`ifdef UART_APB_TIMEOUT_EN
      to_cnt       <= 8'd0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (rx_valid) begin
            if (cmd_reserved_set(rx_data)) begin
              resp_byte <= RESP_NAK;
              state     <= ST_RESPOND;
            end else begin
              PADDR  <= rx_data[CMD_ADDR_MSB:CMD_ADDR_LSB];
              PWRITE <= rx_data[CMD_WRITE_BIT];
              if (rx_data[CMD_WRITE_BIT]) begin
                state <= ST_GET_DATA;
              end else begin
                PSEL  <= 1'b1;
                state <= ST_SETUP;
              end
            end
          end
        end
        ST_GET_DATA: begin
          if (rx_valid) begin
            PWDATA <= rx_data;
            PSEL   <= 1'b1;
            state  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          PENABLE <= 1'b1;
          state   <= ST_ACCESS;
`ifdef UART_APB_TIMEOUT_EN
          to_cnt  <= TIMEOUT_LOAD;
`endif
        end
        ST_ACCESS: begin
          if (PREADY) begin
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            resp_byte <= PWRITE ? RESP_ACK : PRDATA;
            state     <= ST_RESPOND;
          end
`ifdef UART_APB_TIMEOUT_EN
          else if (to_cnt == 8'd0) begin
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            resp_byte <= RESP_TIMEOUT;
            state     <= ST_RESPOND;
          end else begin
            to_cnt <= to_cnt - 8'd1;
          end
`endif
        end
        ST_RESPOND: begin
          // First RESPOND cycle launches the start bit; then 8 data bits and
          // the stop bit are shifted out from {stop, data}.
          if (!tx_active) begin
            TXD          <= 1'b0;
            tx_shift     <= {1'b1, resp_byte};
            tx_bits_left <= 4'd9;
            tx_baud_cnt  <= BIT_LOAD;
            tx_active    <= 1'b1;
          end else if (tx_baud_cnt != 16'd0) begin
            tx_baud_cnt <= tx_baud_cnt - 16'd1;
          end else if (tx_bits_left != 4'd0) begin
            TXD          <= tx_shift[0];
            tx_shift     <= {1'b1, tx_shift[8:1]};
            tx_bits_left <= tx_bits_left - 4'd1;
            tx_baud_cnt  <= BIT_LOAD;
          end else begin
            tx_active <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
